// File: rtl/bp_table_port_scheduler.sv
// Single-port scheduler for the branch-predictor pattern-history table: init sweep,
// lookup/update arbitration, and read-modify-write of buffered commit updates.
module bp_table_port_scheduler #(
    parameter int IDX_BITS   = 10,
    parameter int CTR_BITS   = 2,
    parameter int INIT_VALUE = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_req,
    output logic                            busy,
    input  logic                            lk_valid,
    input  logic [IDX_BITS-1:0]             lk_idx,
    output logic                            lk_ready,
    output logic                            lk_rsp_valid,
    output logic [CTR_BITS-1:0]             lk_rsp_ctr,
    input  logic                            up_valid,
    input  logic [IDX_BITS-1:0]             up_idx,
    input  logic                            up_taken,
    output logic                            up_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            tbl_en,
    output logic                            tbl_we,
    output logic [IDX_BITS-1:0]             tbl_addr,
    output logic [CTR_BITS-1:0]             tbl_wdata,
    input  logic [CTR_BITS-1:0]             tbl_rdata
);

    localparam int                   PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int                   CNT_BITS   = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0]  FULL_COUNT = CNT_BITS'(FIFO_DEPTH);
    localparam logic [IDX_BITS-1:0]  LAST_IDX   = '1;
    localparam logic [CTR_BITS-1:0]  CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0]  CTR_INIT   = CTR_BITS'(INIT_VALUE);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RMW_WR} state_t;

    state_t               state;
    logic [IDX_BITS-1:0]  p;
    logic [IDX_BITS-1:0]  q_idx   [FIFO_DEPTH];
    logic                 q_taken [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [IDX_BITS-1:0]  rmw_idx;
    logic                 rmw_taken;

    logic                 full;
    logic                 empty;
    logic                 run;
    logic                 update_win;
    logic                 push;
    logic                 pop;
    logic [CTR_BITS-1:0]  next_ctr;

    assign full       = (fifo_count == FULL_COUNT);
    assign empty      = (fifo_count == '0);
    assign run        = (state == ST_RUN) && !flush_req;
    // A full FIFO pre-empts lookups so commit updates cannot be starved forever.
    assign update_win = run && (full || (!lk_valid && !empty));
    assign lk_ready   = run && !update_win;
    assign up_ready   = !full && !flush_req;
    assign push       = up_valid && up_ready;
    assign pop        = update_win;
    assign busy       = (state == ST_INIT);
    assign lk_rsp_ctr = tbl_rdata;

    always_comb begin
        if (rmw_taken) next_ctr = (tbl_rdata == CTR_MAX) ? CTR_MAX : tbl_rdata + CTR_BITS'(1);
        else           next_ctr = (tbl_rdata == '0)      ? '0      : tbl_rdata - CTR_BITS'(1);
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        if (!flush_req) begin
            unique case (state)
                ST_INIT: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = p;
                    tbl_wdata = CTR_INIT;
                end
                ST_RUN: begin
                    if (update_win) begin
                        tbl_en   = 1'b1;
                        tbl_addr = q_idx[rd_ptr];
                    end else if (lk_valid) begin
                        tbl_en   = 1'b1;
                        tbl_addr = lk_idx;
                    end
                end
                ST_RMW_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = rmw_idx;
                    tbl_wdata = next_ctr;
                end
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            p            <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            lk_rsp_valid <= 1'b0;
            rmw_idx      <= '0;
            rmw_taken    <= 1'b0;
            // NOTE: the queue storage is only a few flops, so it is cleared too; the SRAM
            // itself is cleared by the init sweep rather than by reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_idx[i]   <= '0;
                q_taken[i] <= 1'b0;
            end
        end else if (flush_req) begin
            state        <= ST_INIT;
            p            <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            lk_rsp_valid <= 1'b0;
        end else begin
            lk_rsp_valid <= lk_valid && lk_ready;
            if (push) begin
                q_idx[wr_ptr]   <= up_idx;
                q_taken[wr_ptr] <= up_taken;
                wr_ptr          <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rmw_idx   <= q_idx[rd_ptr];
                rmw_taken <= q_taken[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_BITS'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_BITS'(1);
                2'b01:   fifo_count <= fifo_count - CNT_BITS'(1);
                default: fifo_count <= fifo_count;
            endcase
            unique case (state)
                ST_INIT: begin
                    p <= p + IDX_BITS'(1);
                    if (p == LAST_IDX) state <= ST_RUN;
                end
                ST_RUN:    if (pop) state <= ST_RMW_WR;
                ST_RMW_WR: state <= ST_RUN;
                default:   state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/bp_table_port_scheduler.md
Name: bp_table_port_scheduler

Overview:
- Sequences all accesses to one single-port, 1-cycle-read-latency pattern-history-counter SRAM used by the branch predictor.
- Arbitrates front-end lookups against commit-time counter updates. Updates arrive from ROB branch commit, are buffered in a FIFO and applied as read-modify-write.
- Owns table initialization: a hardware sweep after reset and on flush, which removes any dependence on simulation-only initial blocks.

Parameters:
IDX_BITS, 10, table index width; table has 2**IDX_BITS entries
CTR_BITS, 2, saturating counter width
INIT_VALUE, 1, value written to every entry by the init sweep (weakly not-taken)
FIFO_DEPTH, 4, update FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low; clock clk
flush_req  in  1  one-cycle pulse: discard pending updates, re-initialize table
busy  out  1  high while the init sweep runs
lk_valid  in  1  lookup request
lk_idx  in  IDX_BITS  lookup index
lk_ready  out  1  lookup accepted this cycle when lk_valid&&lk_ready
lk_rsp_valid  out  1  lookup data valid (one cycle after acceptance)
lk_rsp_ctr  out  CTR_BITS  counter value read
up_valid  in  1  update request from branch commit
up_idx  in  IDX_BITS  index to update
up_taken  in  1  resolved outcome, 1=taken
up_ready  out  1  FIFO can accept an update
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
tbl_en  out  1  SRAM access enable
tbl_we  out  1  SRAM write enable
tbl_addr  out  IDX_BITS  SRAM address
tbl_wdata  out  CTR_BITS  SRAM write data
tbl_rdata  in  CTR_BITS  SRAM read data, valid the cycle after a read

Behaviour:
- States:
  - INIT: sweep pointer p, writes INIT_VALUE at p each cycle.
  - RUN: arbitration.
  - RMW_WR: write phase of an update.
- Reset (rst_n=0 at a clock edge): state=INIT, p=0, FIFO empty, lk_rsp_valid=0, fifo_count=0.
  - During and directly after reset: busy=1, lk_ready=0, tbl_en=1, tbl_we=1, tbl_addr=p (0), tbl_wdata=INIT_VALUE.
- INIT:
  - One write per cycle, p increments.
  - After the write at p=2**IDX_BITS-1, the next state is RUN.
  - Sweep takes exactly 2**IDX_BITS cycles; busy is combinational (state==INIT).
  - lk_ready=0.
  - Updates are still accepted into the FIFO and applied after the sweep.
- RUN arbitration, one SRAM access per cycle:
  1. If fifo_count==FIFO_DEPTH, update wins (starvation guard): lk_ready=0.
  2. Else if lk_valid, lookup wins: tbl_en=1, tbl_we=0, tbl_addr=lk_idx, lk_ready=1.
  3. Else if the FIFO is non-empty, update wins.
- Update win:
  - Issue read of the FIFO head index, pop the head, latch {idx,taken}, go to RMW_WR.
  - While in RUN, lk_ready=0 whenever the update wins.
- RMW_WR:
  - tbl_we=1, tbl_addr=latched idx.
  - tbl_wdata = taken ? min(tbl_rdata+1, 2**CTR_BITS-1) : max(tbl_rdata-1, 0), saturating with no wrap.
  - lk_ready=0; return to RUN.
  - Update throughput is therefore at most 1 per 2 cycles.
- Lookup response:
  - lk_rsp_valid is registered and rises the cycle after acceptance.
  - lk_rsp_ctr = tbl_rdata in that cycle.
  - lk_rsp_ctr is don't-care when lk_rsp_valid=0.
- No bypass: a lookup to an index with a queued or in-flight update returns the pre-update value.
- FIFO:
  - up_ready = (fifo_count!=FIFO_DEPTH) && !flush_req. Ready is not widened by a same-cycle pop.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- flush_req, in any state, has priority over everything:
  - Same cycle: lk_ready=0, up_ready=0, no SRAM access.
  - Next cycle: state=INIT, p=0, FIFO emptied, any in-flight RMW abandoned (no write), lk_rsp_valid=0.
  - flush_req during INIT restarts the sweep at 0.
- rst_n=0 mid-operation has the same effect as flush and additionally clears all registers.

Test Plan:
- Reset, IDX_BITS=4: release rst_n -> busy=1 for exactly 16 cycles, tbl writes addr 0..15 with data 1; cycle 17: busy=0, lk_ready=1.
- After init, lookup idx=5 -> next cycle lk_rsp_valid=1, lk_rsp_ctr=1. Then update idx=5 taken x3 -> writes 2, 3, 3 (saturates). Then not-taken x4 -> writes 2, 1, 0, 0.
- Lookup priority and starvation guard:
  - Hold lk_valid=1 continuously and push 4 updates -> no update issues until fifo_count==4.
  - Then lk_ready=0 for a read+write pair, one update per 2 cycles, until count drops below 4.
- FIFO full, FIFO_DEPTH=4 with lookups saturating:
  - Push 4 -> up_ready=0.
  - 5th up_valid is held, not lost, and is accepted once count drops to 3.
- Flush during RMW_WR with 3 queued updates -> no write to the latched idx, fifo_count=0 next cycle, busy=1 for 16 cycles, then all entries read back 1.
- Updates pushed during the INIT sweep (idx=2 taken, idx=2 taken) -> after busy falls, a lookup of idx=2 returns 3.
